// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline.
//
// Generates the next fetch PC (sequential, branch redirect or a pending
// redirect that could not be issued yet), drives the synchronous instruction
// SRAM, holds the IF-stage PC/valid register and keeps a one-entry buffer so
// the instruction presented to decode survives backpressure.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ds_allowin        decode can accept an instruction this cycle
//   br_bus            {br_stall, br_taken, br_target[31:0]} from decode
//   fs_to_ds_valid    IF holds a valid instruction for decode
//   fs_to_ds_bus      {fs_inst[31:0], fs_pc[31:0]}
//   inst_sram_*       fetch request (en/addr), tied write controls, read data
//                     that arrives one cycle after a cycle with en=1
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ds_allowin,
  input  logic [33:0] br_bus,
  output logic        fs_to_ds_valid,
  output logic [63:0] fs_to_ds_bus,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata
);

  logic        br_stall;
  logic        br_taken;
  logic [31:0] br_target;

  logic        fs_valid_q;
  logic [31:0] fs_pc_q;
  logic        ibuf_valid_q;
  logic [31:0] ibuf_q;
  logic        br_pend_q;
  logic [31:0] br_pend_target_q;

  logic        to_fs_valid;
  logic        pfs_ready_go;
  logic        fs_ready_go;
  logic        fs_allowin;
  logic        issue;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  logic [31:0] fs_inst;
  logic        ibuf_set;
  logic        ibuf_clr;
  logic        br_pend_set;

  assign br_stall  = br_bus[33];
  assign br_taken  = br_bus[32];
  assign br_target = br_bus[31:0];

  // Pre-IF: choose the next fetch address.
  always_comb begin
    to_fs_valid  = ~reset;
    seq_pc       = fs_pc_q + 32'd4;
    // Without a pending redirect, a stalled branch leaves the target unknown.
    pfs_ready_go = ~(br_stall & ~br_pend_q);
    if (br_pend_q) begin
      nextpc = br_pend_target_q;
    end else if (br_taken & ~br_stall) begin
      nextpc = br_target;
    end else begin
      nextpc = seq_pc;
    end
  end

  // IF handshake and fetch issue.
  always_comb begin
    fs_ready_go    = 1'b1;
    fs_allowin     = ~fs_valid_q | (fs_ready_go & ds_allowin);
    issue          = to_fs_valid & pfs_ready_go & fs_allowin;
    fs_to_ds_valid = fs_valid_q & fs_ready_go;
  end

  // Buffer the SRAM word on the first stalled cycle; afterwards the SRAM
  // output is no longer valid because no new request is issued.
  always_comb begin
    ibuf_set    = fs_valid_q & ~ds_allowin & ~ibuf_valid_q;
    ibuf_clr    = fs_to_ds_valid & ds_allowin;
    // br_bus is ignored while a redirect is already pending.
    br_pend_set = br_taken & ~br_stall & ~issue & ~br_pend_q;
    fs_inst     = ibuf_valid_q ? ibuf_q : inst_sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q <= 1'b0;
      fs_pc_q    <= RESET_PC - 32'd4;
    end else begin
      if (fs_allowin) begin
        fs_valid_q <= issue;
      end
      if (issue) begin
        fs_pc_q <= nextpc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || ibuf_clr) begin
      ibuf_valid_q <= 1'b0;
    end else if (ibuf_set) begin
      ibuf_valid_q <= 1'b1;
      ibuf_q       <= inst_sram_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || issue) begin
      br_pend_q <= 1'b0;
    end else if (br_pend_set) begin
      br_pend_q        <= 1'b1;
      br_pend_target_q <= br_target;
    end
  end

  assign fs_to_ds_bus    = {fs_inst, fs_pc_q};
  assign inst_sram_en    = issue;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'b0;

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hbfc00000;

  logic        clk = 1'b0;
  logic        reset;
  logic        ds_allowin;
  logic [33:0] br_bus;
  logic        fs_to_ds_valid;
  logic [63:0] fs_to_ds_bus;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: architectural view of IF.
  bit          m_known = 1'b0;
  bit          m_valid;
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .reset          (reset),
    .ds_allowin     (ds_allowin),
    .br_bus         (br_bus),
    .fs_to_ds_valid (fs_to_ds_valid),
    .fs_to_ds_bus   (fs_to_ds_bus),
    .inst_sram_en   (inst_sram_en),
    .inst_sram_wen  (inst_sram_wen),
    .inst_sram_addr (inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Synchronous SRAM: data only valid after an enabled cycle, garbage otherwise.
  always @(posedge clk) begin
    if (inst_sram_en === 1'b1) inst_sram_rdata <= mem_word(inst_sram_addr);
    else                       inst_sram_rdata <= 32'hdeadbeef ^ $urandom;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, compare outputs with the model, advance the model.
  task automatic step(input bit r, input bit a, input logic [33:0] b);
    bit          redirect;
    bit          tgt_known;
    bit          accept;
    bit          fetch;
    logic [31:0] faddr;
    @(negedge clk);
    reset      = r;
    ds_allowin = a;
    br_bus     = b;
    #1;
    redirect  = 1'b0;
    accept    = 1'b0;
    fetch     = 1'b0;
    faddr     = 32'h0;
    if (!r) begin
      redirect  = !m_pend && b[32] && !b[33];
      tgt_known = m_pend || !b[33];
      accept    = !m_valid || a;
      fetch     = tgt_known && accept;
      if (m_pend)        faddr = m_tgt;
      else if (redirect) faddr = b[31:0];
      else               faddr = m_pc + 32'd4;
    end
    chk("en", {31'b0, inst_sram_en}, {31'b0, fetch});
    if (fetch) chk("addr", inst_sram_addr, faddr);
    if (m_known) begin
      chk("valid", {31'b0, fs_to_ds_valid}, {31'b0, m_valid});
      chk("pc", fs_to_ds_bus[31:0], m_pc);
      if (m_valid) chk("inst", fs_to_ds_bus[63:32], mem_word(m_pc));
    end
    if (r) begin
      m_known = 1'b1;
      m_valid = 1'b0;
      m_pc    = RESET_PC - 32'd4;
      m_pend  = 1'b0;
    end else if (fetch) begin
      m_valid = 1'b1;
      m_pc    = faddr;
      m_pend  = 1'b0;
    end else begin
      if (accept) m_valid = 1'b0;
      if (redirect) begin
        m_pend = 1'b1;
        m_tgt  = b[31:0];
      end
    end
  endtask

  localparam logic [33:0] NoBr = 34'h0;

  initial begin
    logic [31:0] rnd;
    logic [33:0] b;
    bit          r;
    bit          a;
    int          sel;

    reset      = 1'b1;
    ds_allowin = 1'b1;
    br_bus     = NoBr;

    // Reset and first fetches.
    step(1'b1, 1'b1, NoBr);
    step(1'b1, 1'b1, NoBr);
    chk("rst_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk("rst_pc", fs_to_ds_bus[31:0], 32'hbfbffffc);
    chk("tie_wen", {28'b0, inst_sram_wen}, 32'h0);
    chk("tie_wdata", inst_sram_wdata, 32'h0);
    step(1'b0, 1'b1, NoBr);
    chk("first_addr", inst_sram_addr, 32'hbfc00000);
    step(1'b0, 1'b1, NoBr);
    chk("first_pc", fs_to_ds_bus[31:0], 32'hbfc00000);
    chk("second_addr", inst_sram_addr, 32'hbfc00004);

    // Backpressure with corrupted SRAM data after the first stalled cycle.
    step(1'b0, 1'b0, NoBr);
    step(1'b0, 1'b0, NoBr);
    step(1'b0, 1'b0, NoBr);
    chk("stall_inst", fs_to_ds_bus[63:32], mem_word(32'hbfc00004));
    chk("stall_pc", fs_to_ds_bus[31:0], 32'hbfc00004);
    step(1'b0, 1'b1, NoBr);
    chk("release_addr", inst_sram_addr, 32'hbfc00008);

    // Taken branch with delay slot in IF.
    step(1'b0, 1'b1, NoBr);
    step(1'b0, 1'b1, NoBr);
    step(1'b0, 1'b1, {2'b01, 32'hbfc00100});
    chk("br_addr", inst_sram_addr, 32'hbfc00100);
    chk("delay_slot_pc", fs_to_ds_bus[31:0], 32'hbfc00010);
    step(1'b0, 1'b1, NoBr);
    chk("br_pc", fs_to_ds_bus[31:0], 32'hbfc00100);

    // Load-dependent branch stall.
    step(1'b0, 1'b1, {2'b10, 32'h0});
    step(1'b0, 1'b1, {2'b10, 32'h0});
    chk("bstall_en", {31'b0, inst_sram_en}, 32'h0);
    step(1'b0, 1'b1, {2'b01, 32'hbfc00200});
    chk("bstall_addr", inst_sram_addr, 32'hbfc00200);
    step(1'b0, 1'b1, NoBr);

    // Branch arrives during backpressure: must be remembered.
    step(1'b0, 1'b0, {2'b01, 32'hbfc00300});
    step(1'b0, 1'b0, NoBr);
    step(1'b0, 1'b1, NoBr);
    chk("pend_addr", inst_sram_addr, 32'hbfc00300);
    step(1'b0, 1'b1, NoBr);

    // Reset with buffer and pending branch both occupied.
    step(1'b0, 1'b0, {2'b01, 32'hbfc00400});
    step(1'b0, 1'b0, NoBr);
    step(1'b1, 1'b0, NoBr);
    step(1'b0, 1'b1, NoBr);
    chk("rst2_valid", {31'b0, fs_to_ds_valid}, 32'h0);
    chk("rst2_addr", inst_sram_addr, 32'hbfc00000);
    step(1'b0, 1'b1, NoBr);

    // PC wraparound.
    step(1'b0, 1'b1, {2'b01, 32'hfffffffc});
    step(1'b0, 1'b1, NoBr);
    chk("wrap_addr", inst_sram_addr, 32'h00000000);
    step(1'b0, 1'b1, NoBr);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(49) == 0);
      a   = ($urandom_range(9) < 7);
      sel = $urandom_range(99);
      rnd = $urandom;
      if (sel < 12)      b = {2'b10, rnd};
      else if (sel < 27) b = {2'b01, RESET_PC[31:12], rnd[11:2], 2'b00};
      else               b = {2'b00, rnd};
      step(r, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
